// File: rtl/dram_ctrl_pkg.sv
// Shared definitions for the DRAM access controller: FSM state encoding and
// the timeout counter width helper.
package dram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter must hold timeout-1; keep at least one bit when the timeout is disabled.
  function automatic int unsigned cnt_width(input int unsigned t);
    return (t == 0) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/dram_access_ctrl_ack_timer.sv
// Saturating wait counter for the memory acknowledge; expired_o flags the last
// allowed BUSY cycle. A timeout of 0 never expires.
module ack_timer #(
  parameter int unsigned timeout = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  import dram_ctrl_pkg::*;

  localparam int unsigned CW = cnt_width(timeout);
  localparam logic [CW-1:0] LAST = (timeout == 0) ? '0 : CW'(timeout - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (timeout != 0) && (cnt_q == LAST);

endmodule

// File: rtl/dram_access_ctrl.sv
// Initiator-side controller for the word-addressed data memory: sequences a
// single load/store per request, stalls the pipeline and flags a missing ack.
module dram_access_ctrl #(
  parameter int unsigned addr_width = 32,
  parameter int unsigned data_width = 32,
  parameter int unsigned timeout    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [addr_width-1:0] addr_i,
  input  logic [data_width-1:0] wdata_i,
  output logic [data_width-1:0] rdata_o,
  output logic                  stall_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  mem_cs_o,
  output logic                  mem_we_o,
  output logic [addr_width-1:0] mem_addr_o,
  output logic [data_width-1:0] mem_data_o,
  input  logic [data_width-1:0] mem_data_i,
  input  logic                  mem_ack_i
);
  import dram_ctrl_pkg::*;

  state_e                  state_q, state_d;
  logic                    err_q, err_d;
  logic                    we_q, we_d;
  logic [addr_width-1:0]   addr_q, addr_d;
  logic [data_width-1:0]   wdata_q, wdata_d;
  logic [data_width-1:0]   rdata_q, rdata_d;
  logic                    tmr_clr, tmr_en, tmr_expired;

  ack_timer #(
    .timeout(timeout)
  ) u_ack_timer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expired_o(tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          addr_d  = addr_i;
          we_d    = we_i;
          wdata_d = wdata_i;
          tmr_clr = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Ack beats expiry; mem_data_i is only looked at on an acked load.
        if (mem_ack_i) begin
          if (!we_q) begin
            rdata_d = mem_data_i;
          end
          err_d   = 1'b0;
          we_d    = 1'b0;
          state_d = ST_DONE;
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          we_d    = 1'b0;
          state_d = ST_DONE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Chip select decodes straight from the state flop so reset drops it at once.
  assign mem_cs_o   = (state_q == ST_BUSY);
  assign mem_we_o   = we_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = wdata_q;
  assign rdata_o    = rdata_q;
  assign done_o     = (state_q == ST_DONE);
  assign err_o      = (state_q == ST_DONE) && err_q;
  assign stall_o    = ((state_q == ST_IDLE) && req_i) || (state_q == ST_BUSY);

endmodule

// File: tb/tb_dram_access_ctrl.sv
// Scoreboard bench for dram_access_ctrl: a memory responder with per-access
// ack delay, a reference model of memory/rdata, and a done_o monitor.
module tb_dram_access_ctrl;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int          TMO   = 8;
  localparam int          NOACK = 1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_i, we_i;
  logic [AW-1:0] addr_i, mem_addr_o;
  logic [DW-1:0] wdata_i, rdata_o, mem_data_o, mem_data_i;
  logic          stall_o, done_o, err_o, mem_cs_o, mem_we_o, mem_ack_i;

  always #5 clk = ~clk;

  dram_access_ctrl #(
    .addr_width(AW),
    .data_width(DW),
    .timeout   (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .rdata_o   (rdata_o),
    .stall_o   (stall_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .mem_cs_o  (mem_cs_o),
    .mem_we_o  (mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i),
    .mem_ack_i (mem_ack_i)
  );

  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  int            tests = 0;
  int            fails = 0;
  int            cyc   = 0;
  int            cur_delay = NOACK;
  int            busy_cnt  = 0;
  logic [DW-1:0] mem[64];
  logic [DW-1:0] ref_mem[64];
  logic [DW-1:0] ref_rdata = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: acks on the cur_delay-th BUSY edge; garbage on the bus otherwise.
  always @(negedge clk) begin
    if (mem_cs_o) busy_cnt++;
    else          busy_cnt = 0;
    mem_ack_i = mem_cs_o && (busy_cnt == cur_delay);
    if (mem_ack_i && !mem_we_o) mem_data_i = mem[mem_addr_o[7:2]];
    else                        mem_data_i = $urandom;
    if (mem_ack_i && mem_we_o)  mem[mem_addr_o[7:2]] = mem_data_o;
  end

  // Monitor: every done_o pulse is matched against the next scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done_o) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done_o=1 expected no completion (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("err_o", err_o, e.err);
          check("rdata_o", rdata_o, e.rdata);
          check("cs_in_done", mem_cs_o, 0);
          check("we_in_done", mem_we_o, 0);
          check("stall_in_done", stall_o, 0);
        end
      end
    end
  end

  task automatic do_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input int delay);
    exp_t e;
    int   w;
    bit   acked;
    @(negedge clk);
    cur_delay = delay;
    we_i      = we;
    addr_i    = addr;
    wdata_i   = data;
    req_i     = 1'b1;
    acked     = (delay >= 1) && (delay <= TMO);
    e.cyc     = cyc + 1 + (acked ? delay : TMO);
    e.err     = !acked;
    if (acked) begin
      if (we) ref_mem[addr[7:2]] = data;
      else    ref_rdata = ref_mem[addr[7:2]];
    end
    e.rdata = ref_rdata;
    sb.push_back(e);
    #1;
    check("stall_on_req", stall_o, 1);
    w = 0;
    do begin
      @(negedge clk);
      w++;
      if (!done_o) begin
        check("cs_busy", mem_cs_o, 1);
        check("stall_busy", stall_o, 1);
        check("addr_stable", mem_addr_o, addr);
        check("we_stable", mem_we_o, we);
        check("wdata_stable", mem_data_o, data);
      end
    end while (!done_o && w < TMO + 4);
    if (!done_o) begin
      tests++;
      fails++;
      $display("FAIL done_wait: got no done_o after %0d cycles expected completion", w);
    end
    req_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cs"}, mem_cs_o, 0);
    check({tag, "_we"}, mem_we_o, 0);
    check({tag, "_addr"}, mem_addr_o, 0);
    check({tag, "_wdata"}, mem_data_o, 0);
    check({tag, "_rdata"}, rdata_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_stall"}, stall_o, 0);
  endtask

  initial begin
    reset      = 1'b1;
    req_i      = 1'b0;
    we_i       = 1'b0;
    addr_i     = '0;
    wdata_i    = '0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[5]     = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    do_txn(1'b0, 32'h14, 32'h0, 1);
    do_txn(1'b1, 32'h20, 32'h12345678, 2);
    do_txn(1'b0, 32'h20, 32'h0, 5);
    do_txn(1'b0, 32'h33, 32'h0, NOACK);
    do_txn(1'b0, 32'h08, 32'h0, TMO);
    do_txn(1'b1, 32'h0C, 32'hCAFEF00D, TMO);
    do_txn(1'b0, 32'h0C, 32'h0, 3);

    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] a;
      int            d;
      a = AW'(($urandom_range(0, 63) << 2) | $urandom_range(0, 3));
      d = ($urandom_range(0, 9) == 0) ? NOACK : int'($urandom_range(1, TMO));
      do_txn(1'($urandom_range(0, 1)), a, $urandom, d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset in the middle of an access that would otherwise time out.
    @(negedge clk);
    cur_delay = NOACK;
    we_i      = 1'b1;
    addr_i    = 32'h44;
    wdata_i   = 32'hA5A5A5A5;
    req_i     = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_reset_cs", mem_cs_o, 1);
    #2;
    req_i = 1'b0;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    reset     = 1'b0;
    ref_rdata = '0;
    repeat (TMO + 2) @(negedge clk);
    check("no_done_after_reset", sb.size(), 0);

    do_txn(1'b0, 32'h14, 32'h0, 2);
    do_txn(1'b0, 32'h44, 32'h0, 1);

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dram_access_ctrl.md
Name: dram_access_ctrl

Overview:
Initiator-side controller for the word-addressed data memory (DRAM) block: cs/we/addr/data_i in, data_o/ack out. It accepts single-word load/store requests from the MIPS MEM stage and sequences the chip-select/write-enable handshake. It waits for the memory's ack and returns read data. It stalls the pipeline while the access is in flight and flags an error if ack never arrives.

Parameters:
addr_width, 32, byte address width (memory indexes words as addr>>2)
data_width, 32, data word width
timeout, 16, max cycles waiting for mem_ack_i before error; 0 disables timeout

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_i  input  1  CPU access request; held with addr/we/wdata until done_o
we_i  input  1  1 = store, 0 = load
addr_i  input  addr_width  CPU byte address
wdata_i  input  data_width  store data
rdata_o  output  data_width  load data; registered, held until next successful load
stall_o  output  1  pipeline stall request
done_o  output  1  one-cycle completion pulse
err_o  output  1  one-cycle pulse with done_o when the access timed out
mem_cs_o  output  1  memory chip select
mem_we_o  output  1  memory write enable
mem_addr_o  output  addr_width  memory address (byte address, passed unmodified)
mem_data_o  output  data_width  memory write data
mem_data_i  input  data_width  memory read data (may be Z while cs low)
mem_ack_i  input  1  memory completion acknowledge

Behaviour:
- Reset (async, active-high): state IDLE; rdata_o, done_o, err_o, mem_cs_o, mem_we_o, mem_addr_o, mem_data_o, counter = 0. Reset mid-access drops mem_cs_o immediately and discards the access without a done_o pulse.
- FSM states: IDLE, BUSY, DONE.
- IDLE: mem_cs_o = 0. On rising clk with req_i = 1, register addr_i, we_i and wdata_i into mem_addr_o, mem_we_o and mem_data_o. Set mem_cs_o = 1, clear counter, go BUSY.
- BUSY: mem_cs_o = 1; mem_addr_o, mem_we_o and mem_data_o are stable. Each clk:
  - mem_ack_i = 1: if load, rdata_o <= mem_data_i. Go DONE with err flag 0.
  - Otherwise, if timeout != 0 and counter == timeout-1: go DONE with err flag 1; rdata_o is unchanged.
  - Otherwise counter += 1.
- DONE: mem_cs_o = 0, mem_we_o = 0, done_o = 1 and err_o = err flag, both for exactly this cycle. Next state is IDLE unconditionally. A req_i still high in DONE is not accepted; the CPU drops req_i on done_o.
- Ack takes priority over timeout in the same cycle. mem_ack_i is ignored in IDLE and DONE.
- mem_data_i is sampled only on an ack during a load, so a Z bus is never captured.
- stall_o is combinational: (state == IDLE && req_i) || state == BUSY. It is 0 in DONE.
- Latency: req sampled at edge 0. mem_cs_o is high from edge 0. With a memory that acks on edge N, done_o is high in the cycle after edge N. Minimum is 3 cycles from req to done_o.
- Counter width is $clog2(timeout+1), minimum 1. The counter saturates and never wraps.
- A store never modifies rdata_o.

Decomposition:
- Shared package dram_ctrl_pkg holds the state encoding constants (ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2).
- One sub-module, ack_timer: counter with clear/enable and an expired output, parameterised by timeout.
- FSM and datapath registers stay in dram_access_ctrl.

Test Plan:
- Load, memory acks 1 cycle after cs (mem word 5 = 32'hDEADBEEF), req addr 32'h14 we 0:
  - Required: mem_cs_o=1, mem_addr_o=32'h14, mem_we_o=0.
  - Required: done_o pulses; rdata_o=32'hDEADBEEF; err_o=0; stall_o high until the DONE cycle.
- Store addr 32'h20 data 32'h12345678:
  - Required: mem_we_o=1 and mem_data_o=32'h12345678 while cs is high.
  - Required: after done_o, a load from 32'h20 returns 32'h12345678; rdata_o is unchanged by the store.
- Ack delayed 5 cycles (timeout=16):
  - Required: mem_cs_o and mem_addr_o stable for all BUSY cycles.
  - Required: done_o exactly 1 cycle after the ack cycle; counter not wrapped.
- No ack, timeout=4:
  - Required: after 4 BUSY cycles, done_o=1 and err_o=1 together.
  - Required: rdata_o keeps its previous value; mem_cs_o=0 in DONE.
- Ack arrives in the same cycle the counter expires:
  - Required: err_o=0 and read data is captured.
- Reset asserted asynchronously mid-BUSY:
  - Required: mem_cs_o falls without waiting for clk; all outputs are 0; no done_o.
  - Required: the next request after reset release completes normally.
